// File: rtl/ssd_scan_decoder.sv
// Decodes a scan-multiplexed, active-low 4-digit 7-segment bus into hex nibbles with debounce, frame and stale detection.
// Latency: 2+STABLE_CYCLES clocks from a pin change to the captured outputs; no backpressure. Macro SSD_DEC_DP_EN adds dp capture.
module ssd_scan_decoder #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  dig_in,
    output logic [15:0] digits,
    output logic [3:0]  known,
    output logic [3:0]  blank,
    output logic [3:0]  dp_out,
    output logic        frame_stb,
    output logic        decode_err,
    output logic        stale
);

`ifdef SSD_DEC_DP_EN
    localparam int SW = 8;
`else
    localparam int SW = 7;
`endif
    localparam int CB = SW - 7;

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    logic [SW-1:0] seg_s1, seg_s2, seg_prev;
    logic [3:0]    dig_s1, dig_s2, dig_prev;
    logic [7:0]    scnt;
    logic [23:0]   tcnt;
    logic [3:0]    mask;
    state_t        state;

    logic          changed, capture, multi_hot, is_blank;
    logic [4:0]    dec;
    logic [1:0]    idx;
    logic [3:0]    sel;

    function automatic logic [4:0] hex_decode(input logic [6:0] code);
        case (code)
            7'h01:   return {1'b1, 4'h0};
            7'h4F:   return {1'b1, 4'h1};
            7'h12:   return {1'b1, 4'h2};
            7'h06:   return {1'b1, 4'h3};
            7'h4C:   return {1'b1, 4'h4};
            7'h24:   return {1'b1, 4'h5};
            7'h20:   return {1'b1, 4'h6};
            7'h0F:   return {1'b1, 4'h7};
            7'h00:   return {1'b1, 4'h8};
            7'h04:   return {1'b1, 4'h9};
            7'h08:   return {1'b1, 4'hA};
            7'h60:   return {1'b1, 4'hB};
            7'h31:   return {1'b1, 4'hC};
            7'h42:   return {1'b1, 4'hD};
            7'h30:   return {1'b1, 4'hE};
            7'h38:   return {1'b1, 4'hF};
            default: return 5'h00;
        endcase
    endfunction

    // The counter counts repeats after the first sample of a run, so the
    // STABLE_CYCLES-th identical sample is seen when it leaves STABLE_CYCLES-2.
    always_comb begin
        changed   = (seg_s2 != seg_prev) || (dig_s2 != dig_prev);
        capture   = (state == SETTLE) && !changed && (scnt == 8'(STABLE_CYCLES - 2));
        multi_hot = ($countones(~dig_s2) > 1);
        dec       = hex_decode(seg_s2[SW-1:CB]);
        is_blank  = (seg_s2[SW-1:CB] == 7'h7F);
        idx       = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!dig_s2[i]) idx = 2'(i);
        end
        sel = 4'b0001 << idx;
    end

`ifdef SSD_DEC_DP_EN
    logic [3:0] dp_q;
    assign dp_out = dp_q;
`else
    logic unused_dp;
    assign unused_dp = seg_in[0];
    assign dp_out    = 4'h0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1     <= '1;
            seg_s2     <= '1;
            seg_prev   <= '1;
            dig_s1     <= '1;
            dig_s2     <= '1;
            dig_prev   <= '1;
            scnt       <= '0;
            tcnt       <= '0;
            mask       <= '0;
            state      <= IDLE;
            digits     <= '0;
            known      <= '0;
            blank      <= '0;
            frame_stb  <= 1'b0;
            decode_err <= 1'b0;
            stale      <= 1'b0;
`ifdef SSD_DEC_DP_EN
            dp_q       <= '0;
`endif
        end else begin
            seg_s1   <= seg_in[7 -: SW];
            seg_s2   <= seg_s1;
            dig_s1   <= dig_in;
            dig_s2   <= dig_s1;
            seg_prev <= seg_s2;
            dig_prev <= dig_s2;

            if (changed)                           scnt <= '0;
            else if (scnt != 8'(STABLE_CYCLES))    scnt <= scnt + 8'd1;

            if (dig_s2 == 4'hF)  state <= IDLE;
            else if (changed)    state <= SETTLE;
            else if (capture)    state <= HELD;

            frame_stb  <= 1'b0;
            decode_err <= 1'b0;

            if (capture) begin
                tcnt  <= '0;
                stale <= 1'b0;
                if (multi_hot) begin
                    decode_err <= 1'b1;
                end else begin
                    if (dec[4]) digits[{idx, 2'b00} +: 4] <= dec[3:0];
                    known[idx] <= dec[4];
                    blank[idx] <= is_blank;
                    decode_err <= !dec[4] && !is_blank;
`ifdef SSD_DEC_DP_EN
                    dp_q[idx]  <= ~seg_s2[0];
`endif
                    if ((mask | sel) == 4'hF) begin
                        frame_stb <= 1'b1;
                        mask      <= '0;
                    end else begin
                        mask <= mask | sel;
                    end
                end
            end else begin
                if (tcnt != 24'(TIMEOUT_CYCLES)) tcnt <= tcnt + 24'd1;
                stale <= (tcnt >= 24'(TIMEOUT_CYCLES - 1));
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Bench for ssd_scan_decoder: directed display scenarios plus random scan traffic against a run-length reference model.
module tb_ssd_scan_decoder;
    localparam int SC = 16;
    localparam int TO = 100;
    localparam logic [6:0] CODES [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                          7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  seg_in = 8'hFF;
    logic [3:0]  dig_in = 4'hF;
    logic [15:0] digits;
    logic [3:0]  known, blank, dp_out;
    logic        frame_stb, decode_err, stale;

    int total = 0;
    int bad = 0;
    int frame_cnt = 0;
    int err_cnt = 0;

    ssd_scan_decoder #(.STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_in(dig_in),
        .digits(digits), .known(known), .blank(blank), .dp_out(dp_out),
        .frame_stb(frame_stb), .decode_err(decode_err), .stale(stale)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] segb(input int v, input logic dp_on);
        logic [6:0] c;
        c = CODES[v];
        return {c, ~dp_on};
    endfunction

    // ---------------- reference model ----------------
    // A capture happens when the pin value seen two clocks earlier closes a run of exactly SC identical samples.
    logic [11:0] h1, h2, h3;
    int          run;
    int          edge_n = 0;
    int          last_cap = 0;
    logic [3:0]  m_nib [4];
    logic [3:0]  m_known, m_blank, m_dp, m_mask;
    logic        m_frame, m_err;
    bit          m_ok = 0;

    function automatic logic [11:0] cmp_key(input logic [11:0] v);
`ifdef SSD_DEC_DP_EN
        return v;
`else
        return {v[11:1], 1'b0};
`endif
    endfunction

    task automatic model_capture(input logic [3:0] d, input logic [7:0] s);
        int zeros, idx, hit;
        logic [6:0] code;
        zeros = 0; idx = 0; hit = -1;
        code = s[7:1];
        last_cap = edge_n;
        for (int i = 0; i < 4; i++) if (!d[i]) begin zeros++; idx = i; end
        if (zeros > 1) begin
            m_err = 1'b1;
        end else begin
            for (int v = 0; v < 16; v++) if (CODES[v] == code) hit = v;
            if (hit >= 0) begin
                m_nib[idx] = 4'(hit);
                m_known[idx] = 1'b1;
                m_blank[idx] = 1'b0;
            end else begin
                m_known[idx] = 1'b0;
                m_blank[idx] = (code == 7'h7F);
                m_err = (code != 7'h7F);
            end
`ifdef SSD_DEC_DP_EN
            m_dp[idx] = ~s[0];
`endif
            m_mask[idx] = 1'b1;
            if (m_mask == 4'hF) begin
                m_frame = 1'b1;
                m_mask = 4'h0;
            end
        end
    endtask

    always @(posedge clk) begin
        edge_n++;
        m_frame = 1'b0;
        m_err = 1'b0;
        if (!rst_n) begin
            h1 = '1; h2 = '1; h3 = '1;
            run = 1;
            last_cap = edge_n;
            for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
            m_known = 0; m_blank = 0; m_dp = 0; m_mask = 0;
            m_ok = 1;
        end else if (m_ok) begin
            if (cmp_key(h2) == cmp_key(h3)) begin
                if (run < 1000) run++;
            end else begin
                run = 1;
            end
            if (run == SC && h2[11:8] != 4'hF) model_capture(h2[11:8], h2[7:0]);
            h3 = h2; h2 = h1; h1 = {dig_in, seg_in};
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            if (!rst_n) begin
                check("rst_digits", digits, 0);
                check("rst_flags", {known, blank, dp_out, frame_stb, decode_err, stale}, 0);
            end else begin
                check("digits", digits, {m_nib[3], m_nib[2], m_nib[1], m_nib[0]});
                check("known", known, m_known);
                check("blank", blank, m_blank);
                check("dp_out", dp_out, m_dp);
                check("frame_stb", frame_stb, m_frame);
                check("decode_err", decode_err, m_err);
                check("stale", stale, (edge_n - last_cap) >= TO);
            end
            if (rst_n && frame_stb) frame_cnt++;
            if (rst_n && decode_err) err_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n);
        dig_in = d;
        seg_in = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] d, pd;
        logic [7:0] s, ps;
        int r;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        reset_dut();

        // single digit, exact latency
        dig_in = 4'b0111; seg_in = segb(5, 1'b0);
        repeat (17) @(posedge clk); #1;
        check("lat_early_known3", known[3], 0);
        @(posedge clk); #1;
        check("lat_digit4", digits[15:12], 5);
        check("lat_known3", known[3], 1);
        hold(4'b0111, segb(5, 1'b0), 20);

        // full scan 1,2,3,4
        reset_dut();
        frame_cnt = 0;
        hold(4'b1110, segb(1, 1'b0), 40);
        hold(4'b1101, segb(2, 1'b0), 40);
        hold(4'b1011, segb(3, 1'b0), 40);
        check("scan_no_early_frame", frame_cnt, 0);
        hold(4'b0111, segb(4, 1'b0), 40);
        check("scan_frame_once", frame_cnt, 1);
        check("scan_digits", digits, 16'h4321);
        check("scan_known", known, 4'hF);

        // unrecognised pattern on D2
        err_cnt = 0;
        hold(4'b1101, 8'hFD, 40);
        check("bad_err_once", err_cnt, 1);
        check("bad_known1", known[1], 0);
        check("bad_blank1", blank[1], 0);
        check("bad_digit2", digits[7:4], 2);

        // multi-hot digit enables
        err_cnt = 0;
        hold(4'b0011, segb(8, 1'b0), 40);
        check("mh_err_once", err_cnt, 1);
        check("mh_digits", digits, 16'h4321);
        check("mh_known", known, 4'hD);
        frame_cnt = 0;
        hold(4'b1110, segb(5, 1'b0), 40);
        hold(4'b1011, segb(6, 1'b0), 40);
        check("mh_mask_pending", frame_cnt, 0);
        hold(4'b0111, segb(7, 1'b0), 40);
        check("mh_mask_frame", frame_cnt, 1);
        check("mh_digits_after", digits, 16'h7625);

        // glitching below the stability threshold
        frame_cnt = 0; err_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            hold(4'b1110, segb(1, 1'b0), 10);
            hold(4'b1101, segb(2, 1'b0), 10);
        end
        check("glitch_no_frame", frame_cnt, 0);
        check("glitch_no_err", err_cnt, 0);
        check("glitch_digits", digits, 16'h7625);
        check("glitch_stale", stale, 1);

        // reset in the middle of settling
        dig_in = 4'b1011; seg_in = segb(9, 1'b0);
        repeat (12) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_digits", digits, 0);
        check("midrst_known", known, 0);
        check("midrst_stale", stale, 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (17) @(posedge clk); #1;
        check("midrst_early_known2", known[2], 0);
        @(posedge clk); #1;
        check("midrst_known2", known[2], 1);
        check("midrst_digits_after", digits, 16'h0900);

        // random scan traffic
        pd = 4'b1110; ps = segb(0, 1'b0);
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 11);
            if (r < 8) begin
                d = 4'b0001 << $urandom_range(0, 3);
                d = ~d;
            end else if (r == 8) begin
                d = 4'hF;
            end else begin
                d = 4'($urandom);
            end
            r = $urandom_range(0, 9);
            if (r < 6)       s = segb($urandom_range(0, 15), 1'($urandom));
            else if (r == 6) s = {7'h7F, 1'($urandom)};
            else if (r == 7) s = 8'($urandom);
            else begin
                d = pd;
                s = ps ^ 8'h01;
            end
            if ($urandom_range(0, 99) == 0) reset_dut();
            hold(d, s, $urandom_range(1, 40));
            pd = d; ps = s;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
